bram2_wr_seq_l9: RTL and testbench
==================================

Name: bram2_wr_seq_l9

Overview:
- Write-side sequencer for BRAM2 in layer 9.
- Accepts pairs of result words from the layer-9 output path and turns them into dual-port BRAM2 write addresses, strobes and data.
- Uses the same quadrant/offset address map that the layer-9 read-address logic consumes: addr = {x5, y5}, with port 2 at y5+8.
- Sits between the layer-9 output accumulator and BRAM2 ports 1 and 2.

Parameters:
- DATA_W, 16, width of each result word and of the BRAM2 data ports.
- NX, 8, rows per quadrant pass; legal 1..8.
- NY, 8, columns per quadrant pass; legal 1..8.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a full frame. Honoured only in IDLE.
- in_valid  in  1  data1/data2 hold a valid beat.
- in_ready  out  1  sequencer can accept a beat.
- data1  in  DATA_W  result word for port 1.
- data2  in  DATA_W  result word for port 2.
- we1  out  1  BRAM2 port-1 write enable.
- we2  out  1  BRAM2 port-2 write enable.
- addr1  out  10  BRAM2 port-1 address.
- addr2  out  10  BRAM2 port-2 address.
- din1  out  DATA_W  BRAM2 port-1 write data.
- din2  out  DATA_W  BRAM2 port-2 write data.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse coincident with the final write strobe.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; counters x, y, L = 0.
  - we1, we2, done, busy = 0.
  - addr1, addr2, din1, din2 = 0.
- State machine:
  - IDLE -> RUN on start.
  - RUN -> IDLE on acceptance of the last beat.
  - No other states.
- Handshake:
  - in_ready = (state==RUN), combinational from state only.
  - A beat is accepted on a rising edge where in_valid && in_ready.
  - in_valid low in RUN stalls the sequencer; counters hold and no strobe is issued.
- Counters:
  - y is innermost (0..NY-1), then x (0..NX-1), then quadrant L (0..3).
  - All three advance only on acceptance. y wraps to 0 and increments x; x wraps to 0 and increments L.
  - Last beat is (L=3, x=NX-1, y=NY-1). On it, counters clear to 0 and state returns to IDLE.
  - Frame length: 4*NX*NY beats, i.e. 256 with default parameters.
- Address map (5-bit zero-extended x5, y5; all sums are 5-bit):
  - x5 = x + (L[1] ? 8 : 0).
  - yb = y + (L[0] ? 16 : 0).
  - addr1 = {x5, yb}.
  - addr2 = {x5, yb+8}.
- Output timing (latency 1 cycle):
  - Outputs are registered. The edge that accepts a beat loads addr1/2, din1/2 and sets we1=we2=1 for exactly one cycle.
  - When no beat is accepted, we1=we2=0. Addresses and data hold their last values.
  - done=1 in the same cycle as the final we pair; 0 otherwise.
- busy = (state==RUN).
- start while in RUN is ignored, with no restart and no counter change.
- start in the cycle done is high is accepted, because state is already IDLE.
- in_valid while in IDLE is ignored (in_ready=0).
- Reset mid-frame: aborts immediately with no further strobes. The next frame starts from L=0, x=0, y=0.

Optional Feature:
- Macro: L9_WR_RELU_EN.
- Defined: data1/data2 are treated as signed two's complement. Any negative word is written as 0; non-negative words pass unchanged. This adds no extra latency (clamp precedes the output register).
- Undefined: data is written bit-exact.

Decomposition:
- Shared package l9_pkg holds:
  - state typedef (IDLE, RUN);
  - BRAM2_ADDR_W=10;
  - quadrant offsets QX_OFF=8, QY_OFF=16, P2_OFF=8.
- One natural sub-module: bram2_addr_map_l9. It is combinational and maps (x, y, L) to (addr1, addr2); the read side can reuse it.
- Counters, FSM and output registers stay in the top module.

Test Plan:
- Reset/idle: hold rst_n=0 with random inputs -> all outputs 0. Release, drive in_valid=1 without start -> in_ready=0 and no we.
- First beat: start, then beat data1=0x0011, data2=0x0022 -> next cycle we1=we2=1, addr1=0x000, addr2=0x008, din1=0x0011, din2=0x0022.
- Quadrant boundaries: stream beats continuously.
  - Beat 64 (L=1, x=0, y=0) -> addr1=0x010, addr2=0x018.
  - Beat 128 (L=2) -> addr1=0x100, addr2=0x108.
  - Beat 255 -> addr1=0x1F7, addr2=0x1FF with done=1, then busy=0.
- Backpressure: toggle in_valid pseudo-randomly through a frame -> exactly 256 we pairs, and no address is repeated or skipped. Pulsing start mid-frame changes nothing.
- Reset mid-frame: assert rst_n low after 37 beats -> outputs clear at once. A new start then writes first at addr 0x000.
- Feature: with L9_WR_RELU_EN, data1=0x8001, data2=0x7FFF -> din1=0x0000, din2=0x7FFF. Without the macro -> din1=0x8001.

Source files
------------

// File: rtl/l9_pkg.sv
// Shared layer-9 BRAM2 definitions: sequencer state encoding and the
// quadrant/offset constants of the BRAM2 address map.
package l9_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int BRAM2_ADDR_W = 10;
    localparam int QX_OFF       = 8;
    localparam int QY_OFF       = 16;
    localparam int P2_OFF       = 8;

endpackage

// File: rtl/bram2_addr_map_l9.sv
// Combinational BRAM2 address map: (x, y, quadrant) -> port-1/port-2 addresses.
// Every sum is 5 bits wide, so the port-2 offset wraps inside the row.
module bram2_addr_map_l9
    import l9_pkg::*;
(
    input  logic [2:0]              x_i,
    input  logic [2:0]              y_i,
    input  logic [1:0]              l_i,
    output logic [BRAM2_ADDR_W-1:0] addr1_o,
    output logic [BRAM2_ADDR_W-1:0] addr2_o
);

    logic [4:0] x5;
    logic [4:0] yb;
    logic [4:0] yb_p2;

    always_comb begin
        x5      = {2'b00, x_i} + (l_i[1] ? 5'(QX_OFF) : 5'd0);
        yb      = {2'b00, y_i} + (l_i[0] ? 5'(QY_OFF) : 5'd0);
        yb_p2   = yb + 5'(P2_OFF);
        addr1_o = {x5, yb};
        addr2_o = {x5, yb_p2};
    end

endmodule

// File: rtl/bram2_wr_seq_l9.sv
// Layer-9 BRAM2 write sequencer: turns accepted result-word pairs into
// registered dual-port write strobes. Optional macro L9_WR_RELU_EN clamps negative words to 0.
module bram2_wr_seq_l9
    import l9_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NX     = 8,
    parameter int NY     = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       data1,
    input  logic [DATA_W-1:0]       data2,
    output logic                    we1,
    output logic                    we2,
    output logic [BRAM2_ADDR_W-1:0] addr1,
    output logic [BRAM2_ADDR_W-1:0] addr2,
    output logic [DATA_W-1:0]       din1,
    output logic [DATA_W-1:0]       din2,
    output logic                    busy,
    output logic                    done
);

    localparam logic [2:0] X_LAST = 3'(NX - 1);
    localparam logic [2:0] Y_LAST = 3'(NY - 1);

    state_e                  state_q;
    logic [2:0]              x_q, y_q;
    logic [1:0]              l_q;
    logic [2:0]              x_d, y_d;
    logic [1:0]              l_d;
    logic                    we1_q, we2_q, done_q;
    logic [BRAM2_ADDR_W-1:0] addr1_q, addr2_q;
    logic [BRAM2_ADDR_W-1:0] addr1_d, addr2_d;
    logic [DATA_W-1:0]       din1_q, din2_q;
    logic [DATA_W-1:0]       din1_d, din2_d;
    logic                    accept;
    logic                    last_beat;

    bram2_addr_map_l9 u_addr_map (
        .x_i     (x_q),
        .y_i     (y_q),
        .l_i     (l_q),
        .addr1_o (addr1_d),
        .addr2_o (addr2_d)
    );

    // Valid/ready: a beat transfers on a rising edge with in_valid && in_ready;
    // in_ready depends on state only, never on in_valid.
    assign in_ready = (state_q == ST_RUN);
    assign busy     = (state_q == ST_RUN);

    always_comb begin
        accept    = (state_q == ST_RUN) && in_valid;
        last_beat = (l_q == 2'd3) && (x_q == X_LAST) && (y_q == Y_LAST);
        y_d       = y_q;
        x_d       = x_q;
        l_d       = l_q;
        if (last_beat) begin
            y_d = 3'd0;
            x_d = 3'd0;
            l_d = 2'd0;
        end else if (y_q == Y_LAST) begin
            y_d = 3'd0;
            if (x_q == X_LAST) begin
                x_d = 3'd0;
                l_d = l_q + 2'd1;
            end else begin
                x_d = x_q + 3'd1;
            end
        end else begin
            y_d = y_q + 3'd1;
        end
`ifdef L9_WR_RELU_EN
        din1_d = data1[DATA_W-1] ? '0 : data1;
        din2_d = data2[DATA_W-1] ? '0 : data2;
`else
        din1_d = data1;
        din2_d = data2;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            x_q     <= 3'd0;
            y_q     <= 3'd0;
            l_q     <= 2'd0;
            we1_q   <= 1'b0;
            we2_q   <= 1'b0;
            done_q  <= 1'b0;
            addr1_q <= '0;
            addr2_q <= '0;
            din1_q  <= '0;
            din2_q  <= '0;
        end else begin
            we1_q  <= 1'b0;
            we2_q  <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) state_q <= ST_RUN;
                end
                ST_RUN: begin
                    if (accept) begin
                        we1_q   <= 1'b1;
                        we2_q   <= 1'b1;
                        addr1_q <= addr1_d;
                        addr2_q <= addr2_d;
                        din1_q  <= din1_d;
                        din2_q  <= din2_d;
                        x_q     <= x_d;
                        y_q     <= y_d;
                        l_q     <= l_d;
                        if (last_beat) begin
                            done_q  <= 1'b1;
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign we1   = we1_q;
    assign we2   = we2_q;
    assign done  = done_q;
    assign addr1 = addr1_q;
    assign addr2 = addr2_q;
    assign din1  = din1_q;
    assign din2  = din2_q;

endmodule

// File: tb/tb_bram2_wr_seq_l9.sv
// Bench for bram2_wr_seq_l9: beat-index reference model, per-cycle compare,
// literal boundary checks. Honours L9_WR_RELU_EN when defined.
module tb_bram2_wr_seq_l9;

  localparam int DW    = 16;
  localparam int NX    = 8;
  localparam int NY    = 8;
  localparam int FRAME = 4 * NX * NY;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] data1 = '0;
  logic [DW-1:0] data2 = '0;
  logic          in_ready, we1, we2, busy, done;
  logic [9:0]    addr1, addr2;
  logic [DW-1:0] din1, din2;

  bram2_wr_seq_l9 #(.DATA_W(DW), .NX(NX), .NY(NY)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .data1    (data1),
    .data2    (data2),
    .we1      (we1),
    .we2      (we2),
    .addr1    (addr1),
    .addr2    (addr2),
    .din1     (din1),
    .din2     (din2),
    .busy     (busy),
    .done     (done)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic          done;
    logic [9:0]    a1;
    logic [9:0]    a2;
    logic [DW-1:0] d1;
    logic [DW-1:0] d2;
  } wr_t;

  function automatic logic [DW-1:0] relu(input logic [DW-1:0] v);
`ifdef L9_WR_RELU_EN
    return (v[DW-1]) ? '0 : v;
`else
    return v;
`endif
  endfunction

  // Write expected for the n-th beat of a frame, from the address-map rules.
  function automatic wr_t beat_model(input int n, input logic [DW-1:0] a, input logic [DW-1:0] b);
    wr_t w;
    int l, x, y, row, col;
    l   = n / (NX * NY);
    x   = (n / NY) % NX;
    y   = n % NY;
    row = (x + 8 * (l / 2)) % 32;
    col = (y + 16 * (l % 2)) % 32;
    w.a1   = 10'(row * 32 + col);
    w.a2   = 10'(row * 32 + ((col + 8) % 32));
    w.d1   = relu(a);
    w.d2   = relu(b);
    w.done = (n == FRAME - 1);
    return w;
  endfunction

  // scoreboard
  wr_t exp_q[$];
  wr_t last_w = '0;
  bit  m_run = 1'b0;
  int  m_n = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run = 1'b0;
      m_n   = 0;
      exp_q.delete();
    end else if (!m_run) begin
      if (start) m_run = 1'b1;
    end else if (in_valid) begin
      exp_q.push_back(beat_model(m_n, data1, data2));
      m_n++;
      if (m_n == FRAME) begin
        m_n   = 0;
        m_run = 1'b0;
      end
    end
  end

  int wr_cnt = 0;
  int dup = 0;
  int frame_id = 0;
  int seen_tag [1024];

  always @(negedge clk) begin
    bit exp_we;
    exp_we = 1'b0;
    if (!rst_n) begin
      last_w = '0;
    end else if (exp_q.size() > 0) begin
      last_w = exp_q.pop_front();
      exp_we = 1'b1;
    end
    chk("cyc_we1", 32'(we1), 32'(exp_we));
    chk("cyc_we2", 32'(we2), 32'(exp_we));
    chk("cyc_done", 32'(done), 32'(exp_we & last_w.done));
    chk("cyc_busy", 32'(busy), 32'(m_run));
    chk("cyc_in_ready", 32'(in_ready), 32'(m_run));
    chk("cyc_addr1", 32'(addr1), 32'(last_w.a1));
    chk("cyc_addr2", 32'(addr2), 32'(last_w.a2));
    chk("cyc_din1", 32'(din1), 32'(last_w.d1));
    chk("cyc_din2", 32'(din2), 32'(last_w.d2));
    if (rst_n && we1) begin
      wr_cnt++;
      if (seen_tag[addr1] == frame_id) dup++;
      seen_tag[addr1] = frame_id;
    end
  end

  initial begin
    int  wr0, dup0, cyc, miss;
    bit  got_done;
    wr_t w;

    // reset with random inputs
    repeat (6) begin
      @(negedge clk);
      start    = 1'($urandom_range(0, 1));
      in_valid = 1'($urandom_range(0, 1));
      data1    = DW'($urandom);
      data2    = DW'($urandom);
    end
    @(negedge clk);
    chk("rst_we1", 32'(we1), 32'd0);
    chk("rst_addr2", 32'(addr2), 32'd0);
    chk("rst_din1", 32'(din1), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    start    = 1'b0;
    in_valid = 1'b1;
    #2 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_in_ready", 32'(in_ready), 32'd0);
    chk("idle_we1", 32'(we1), 32'd0);

    // frame 1: continuous stream with boundary checks
    frame_id = 1;
    in_valid = 1'b0;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b1;
    data1    = 16'h0011;
    data2    = 16'h0022;
    @(negedge clk);
    chk("first_we1", 32'(we1), 32'd1);
    chk("first_we2", 32'(we2), 32'd1);
    chk("first_addr1", 32'(addr1), 32'h000);
    chk("first_addr2", 32'(addr2), 32'h008);
    chk("first_din1", 32'(din1), 32'h0011);
    chk("first_din2", 32'(din2), 32'h0022);
    for (int k = 1; k < FRAME; k++) begin
      data1 = DW'($urandom);
      data2 = DW'($urandom);
      @(negedge clk);
      if (k == 64) begin
        chk("q1_addr1", 32'(addr1), 32'h010);
        chk("q1_addr2", 32'(addr2), 32'h018);
      end
      if (k == 128) begin
        chk("q2_addr1", 32'(addr1), 32'h100);
        chk("q2_addr2", 32'(addr2), 32'h108);
      end
      if (k == FRAME - 1) begin
        chk("last_addr1", 32'(addr1), 32'h1F7);
        chk("last_addr2", 32'(addr2), 32'h1FF);
        chk("last_done", 32'(done), 32'd1);
        chk("last_busy", 32'(busy), 32'd0);
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("post_done", 32'(done), 32'd0);
    chk("post_hold_addr1", 32'(addr1), 32'h1F7);

    // frame 2: random backpressure and stray start pulses
    frame_id = 2;
    wr0      = wr_cnt;
    dup0     = dup;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    cyc      = 0;
    got_done = 1'b0;
    while (!got_done && cyc < 4000) begin
      in_valid = 1'($urandom_range(0, 1));
      data1    = DW'($urandom);
      data2    = DW'($urandom);
      start    = ($urandom_range(0, 15) == 0);
      @(negedge clk);
      cyc++;
      if (done) got_done = 1'b1;
    end
    start    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("bp_done_seen", 32'(got_done), 32'd1);
    chk("bp_write_count", 32'(wr_cnt - wr0), 32'(FRAME));
    chk("bp_dup_addr", 32'(dup - dup0), 32'd0);
    miss = 0;
    for (int n = 0; n < FRAME; n++) begin
      w = beat_model(n, '0, '0);
      if (seen_tag[w.a1] != 2) miss++;
    end
    chk("bp_missing_addr", 32'(miss), 32'd0);

    // frame 3: reset after 37 beats, then restart from address 0
    frame_id = 3;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b1;
    repeat (37) begin
      data1 = DW'($urandom);
      data2 = DW'($urandom);
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_we1", 32'(we1), 32'd0);
    chk("midrst_addr1", 32'(addr1), 32'd0);
    chk("midrst_din1", 32'(din1), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b1;
    data1    = 16'h8001;
    data2    = 16'h7FFF;
    @(negedge clk);
    in_valid = 1'b0;
    chk("restart_we1", 32'(we1), 32'd1);
    chk("restart_addr1", 32'(addr1), 32'h000);
    chk("restart_addr2", 32'(addr2), 32'h008);
`ifdef L9_WR_RELU_EN
    chk("relu_din1", 32'(din1), 32'h0000);
`else
    chk("raw_din1", 32'(din1), 32'h8001);
`endif
    chk("din2_pos", 32'(din2), 32'h7FFF);
    repeat (3) @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
